rv_instr_encoder: RTL



---
 rtl/rv_instr_encoder_pkg.sv | 49 ++++
 rtl/rv_instr_encoder_if.sv | 31 +++
 rtl/rv_instr_encoder_field_pack.sv | 38 +++
 rtl/rv_instr_encoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rv_instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_enc_pkg
// Brief    : Op codes, RV32I opcode/funct fields and FSM state codes.
// Revision : 1.0 - initial release
// ============================================================================
package rv_enc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_SW   = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    // One-hot codes double as the debug values seen on cur/next.
    typedef enum logic [7:0] {
        ST_IDLE   = 8'h01,
        ST_ACCEPT = 8'h02,
        ST_ENCODE = 8'h04,
        ST_WRITE  = 8'h08,
        ST_FULL   = 8'h10
    } state_t;

    function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_encoder_if
// Brief    : Field-bundle handshake plus instruction-memory write port.
// Revision : 1.0 - initial release
// ============================================================================
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [11:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, op, rd, rs1, rs2, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/rv_instr_encoder_field_pack.sv
`default_nettype none
// ============================================================================
// Module   : rv_field_pack
// Brief    : Combinational RV32I field assembler; flags unsupported op codes.
// Revision : 1.0 - initial release
// ============================================================================
module rv_field_pack
    import rv_enc_pkg::*;
(
    input  wire logic [3:0]  i_op,
    input  wire logic [4:0]  i_rd,
    input  wire logic [4:0]  i_rs1,
    input  wire logic [4:0]  i_rs2,
    input  wire logic [11:0] i_imm,
    output logic      [31:0] o_word,
    output logic             o_illegal
);

    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:  o_word = pack_r(F7_BASE, i_rs2, i_rs1, F3_ADD, i_rd);
            OP_SUB:  o_word = pack_r(F7_SUB,  i_rs2, i_rs1, F3_ADD, i_rd);
            OP_AND:  o_word = pack_r(F7_BASE, i_rs2, i_rs1, F3_AND, i_rd);
            OP_OR:   o_word = pack_r(F7_BASE, i_rs2, i_rs1, F3_OR,  i_rd);
            OP_ADDI: o_word = {i_imm, i_rs1, F3_ADD, i_rd, OPC_OPIMM};
            OP_LW:   o_word = {i_imm, i_rs1, F3_W, i_rd, OPC_LOAD};
            OP_SW:   o_word = {i_imm[11:5], i_rs2, i_rs1, F3_W, i_imm[4:0], OPC_STORE};
            // imm carries offset[12:1], so imm[11] is offset bit 12 and imm[10] is bit 11.
            OP_BEQ:  o_word = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, F3_BEQ,
                               i_imm[3:0], i_imm[10], OPC_BRANCH};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_encoder
// Brief    : Assembles RV32I words and writes them sequentially to IMEM.
// Revision : 1.0 - initial release
// ============================================================================
module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         start,
    rv_instr_encoder_if.slave bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [7:0]        cur,
    output logic [7:0]        next
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [11:0]       r_imm;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic              w_capture;
    logic              w_load;
    logic              w_write;
    logic              w_set_err;
    logic [31:0]       w_word;
    logic              w_illegal;

    rv_field_pack u_pack (
        .i_op      (r_op),
        .i_rd      (r_rd),
        .i_rs1     (r_rs1),
        .i_rs2     (r_rs2),
        .i_imm     (r_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= 4'h0;
            r_rd    <= 5'h0;
            r_rs1   <= 5'h0;
            r_rs2   <= 5'h0;
            r_imm   <= 12'h0;
            r_wdata <= 32'h0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_op  <= bus.op;
                r_rd  <= bus.rd;
                r_rs1 <= bus.rs1;
                r_rs2 <= bus.rs2;
                r_imm <= bus.imm;
            end
            if (w_load) begin
                r_wdata <= w_word;
            end
            if (start) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_write) begin
                    r_count <= r_count + 1'b1;
                end
                if (w_set_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // start wins in every state, which also suppresses the write strobe.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_write   = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (start) begin
                    w_next = ST_ACCEPT;
                end else if (bus.in_valid) begin
                    w_capture = 1'b1;
                    w_next    = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                if (start) begin
                    w_next = ST_ACCEPT;
                end else if (w_illegal) begin
                    w_set_err = 1'b1;
                    w_next    = ST_ACCEPT;
                end else begin
                    w_load = 1'b1;
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (start) begin
                    w_next = ST_ACCEPT;
                end else begin
                    w_write = 1'b1;
                    w_next  = (r_count + 1'b1 == C_DEPTH) ? ST_FULL : ST_ACCEPT;
                end
            end
            ST_FULL: begin
                if (start) w_next = ST_ACCEPT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (r_state == ST_ACCEPT);
    assign bus.mem_we    = w_write;
    assign bus.mem_addr  = r_count[ADDR_W-1:0];
    assign bus.mem_wdata = r_wdata;
    assign count         = r_count;
    assign full          = (r_count == C_DEPTH);
    assign err           = r_err;
    assign cur           = r_state;
    assign next          = w_next;

endmodule
`default_nettype wire
